handshake_const_rr_arbiter: RTL and testbench
=============================================

Name: handshake_const_rr_arbiter

Overview:
- Shares one constant-source output channel between NUM_REQ control-token requesters, using round-robin arbitration.
- Each accepted ctrl token produces one output token carrying the requester's table constant and its index.
- Output is registered in a one-entry skid-free pipeline buffer.
- Sits between dataflow control branches (switch-case arms of the softclip datapath) and a single downstream consumer of coefficient tokens.

Parameters:
- NUM_REQ, 4, number of requester control channels; 2..8.
- DATA_WIDTH, 12, width of each constant and of outs.
- IDX_WIDTH, 2, width of outs_index; must be >= clog2(NUM_REQ).
- CONSTS, 48'h800_7FF_A52_5AE, flattened table; entry i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]; entry 0 = 12'h5AE.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- ctrl_valid  input  NUM_REQ  per-requester token valid.
- ctrl_ready  output  NUM_REQ  per-requester token ready; at most one bit high per cycle.
- outs  output  DATA_WIDTH  constant of the granted requester.
- outs_index  output  IDX_WIDTH  index of the requester that produced the current outs token.
- outs_valid  output  1  output token valid.
- outs_ready  input  1  downstream ready.

Behaviour:
- Reset values: outs_valid=0, outs=0, outs_index=0, priority pointer ptr=0, ctrl_ready=0.
- Reset clears any buffered token; tokens in flight at reset are dropped, not replayed.
- Load enable: load = !outs_valid || outs_ready. This is a combinational path from outs_ready to ctrl_ready, and is accepted.
- Arbitration (combinational): search ctrl_valid starting at index ptr, ascending, wrapping NUM_REQ-1 -> 0. The first set bit is grant g.
- ctrl_ready[g] = load && |ctrl_valid. All other ctrl_ready bits are 0. ctrl_ready is 0 when no valid or !load.
- ctrl_ready never depends on ctrl_valid of non-granted channels beyond the priority search.
- Accept: a handshake on channel g occurs when ctrl_valid[g] && ctrl_ready[g]. On the next rising edge:
  - outs <= CONSTS[g]
  - outs_index <= g
  - outs_valid <= 1
  - ptr <= (g+1) mod NUM_REQ
- Drain: if outs_valid && outs_ready and no accept this cycle, outs_valid <= 0. outs and outs_index hold their last value.
- Simultaneous drain and accept: the new token replaces the old one in the same edge. This gives full throughput of 1 token/cycle.
- Stall: outs_valid && !outs_ready means outs, outs_index and outs_valid hold stable, and all ctrl_ready are 0.
- Latency: accept at cycle N gives outs_valid at cycle N+1.
- ptr changes only on accept. With no requests it holds, so idle cycles do not rotate priority.
- Fairness: with all requesters continuously valid and outs_ready=1, grants cycle 0,1,2,3,0,... Any continuously valid requester is served within NUM_REQ accepts.
- Wrap-around: ptr=NUM_REQ-1 with grant NUM_REQ-1 sets ptr to 0.
- Non-power-of-two NUM_REQ wraps modulo NUM_REQ. Index values >= NUM_REQ are never produced.
- A requester deasserting ctrl_valid without handshake is legal. Arbitration simply re-evaluates on the next cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then ctrl_valid=0 -> outs_valid=0, outs=0, outs_index=0, ctrl_ready=0 for 5 cycles.
- Single request: ctrl_valid=4'b0001, outs_ready=1 -> ctrl_ready=4'b0001. Next cycle outs=12'h5AE, outs_index=0, outs_valid=1. ptr=1.
- All requesting, outs_ready=1 for 8 cycles -> outs_index sequence 0,1,2,3,0,1,2,3. outs sequence 5AE,A52,7FF,800 repeating. One token per cycle.
- Backpressure: all requesting, outs_ready=0 for 3 cycles after the first token -> outs=12'h5AE held stable, ctrl_ready=0000. After outs_ready=1, the next token is index 1 (12'hA52) with no token lost or duplicated.
- Priority wrap: preload ptr=3 by granting requester 2, then ctrl_valid=4'b1001 -> grant 3 (12'h800), then grant 0 (12'h5AE).
- Reset mid-operation: outs_valid=1, outs_ready=0, rst pulsed 1 cycle -> next cycle outs_valid=0, ptr=0. With ctrl_valid=4'b0110 afterwards, the first grant is index 1.

Source files
------------

// File: rtl/handshake_const_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : handshake_const_rr_arbiter
// Description : Round-robin arbiter sharing one registered constant-token
//               output channel between NUM_REQ control-token requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module handshake_const_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 12,
  parameter int IDX_WIDTH  = 2,
  parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONSTS = 48'h800_7FF_A52_5AE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    ctrl_valid,
  output logic [NUM_REQ-1:0]    ctrl_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic [IDX_WIDTH-1:0]  outs_index,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  logic [IDX_WIDTH-1:0]  r_ptr;
  logic [DATA_WIDTH-1:0] r_outs;
  logic [IDX_WIDTH-1:0]  r_outs_index;
  logic                  r_outs_valid;

  logic                  w_load;
  logic                  w_found;
  logic                  w_accept;
  logic [IDX_WIDTH-1:0]  w_grant;
  logic [IDX_WIDTH-1:0]  w_next_ptr;
  logic [DATA_WIDTH-1:0] w_const;
  logic [NUM_REQ-1:0]    w_ready;

  // The buffer can take a new token when empty or when its token leaves now.
  assign w_load = !r_outs_valid || outs_ready;

  // Two ascending passes: indices at/above ptr first, then the wrapped ones.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && ctrl_valid[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_grant = IDX_WIDTH'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && ctrl_valid[i] && (i < int'(r_ptr))) begin
        w_found = 1'b1;
        w_grant = IDX_WIDTH'(i);
      end
    end
  end

  assign w_accept = w_load && w_found && !rst;

  always_comb begin
    w_ready = '0;
    w_const = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ready[i] = w_accept && (int'(w_grant) == i);
      if (int'(w_grant) == i) begin
        w_const = CONSTS[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_next_ptr = (int'(w_grant) == NUM_REQ - 1) ? '0 : w_grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_outs       <= '0;
      r_outs_index <= '0;
      r_outs_valid <= 1'b0;
    end else if (w_accept) begin
      // A new token overwrites any token draining on this same edge.
      r_ptr        <= w_next_ptr;
      r_outs       <= w_const;
      r_outs_index <= w_grant;
      r_outs_valid <= 1'b1;
    end else if (r_outs_valid && outs_ready) begin
      r_outs_valid <= 1'b0;
    end
  end

  assign ctrl_ready = w_ready;
  assign outs       = r_outs;
  assign outs_index = r_outs_index;
  assign outs_valid = r_outs_valid;

endmodule
`default_nettype wire

// File: tb/tb_handshake_const_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_handshake_const_rr_arbiter
// Description : Table-driven, scoreboard-checked bench for the RR arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_handshake_const_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  ctrl_valid;
  logic [3:0]  ctrl_ready;
  logic [11:0] outs;
  logic [1:0]  outs_index;
  logic        outs_valid;
  logic        outs_ready;

  handshake_const_rr_arbiter #(
    .NUM_REQ   (4),
    .DATA_WIDTH(12),
    .IDX_WIDTH (2),
    .CONSTS    (48'h800_7FF_A52_5AE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready),
    .outs      (outs),
    .outs_index(outs_index),
    .outs_valid(outs_valid),
    .outs_ready(outs_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] cv;
    logic       ordy;
    logic [3:0] exp_ready;
    logic       chk_zero;
  } vec_t;

  typedef struct {
    logic [11:0] data;
    logic [1:0]  idx;
  } tok_t;

  vec_t        vecs[$];
  tok_t        sb[$];
  logic [11:0] c_tab[4];
  int          n_tests;
  int          n_fail;

  function automatic void add(input logic r, input logic [3:0] cv,
                              input logic ordy, input logic [3:0] er,
                              input logic cz);
    vec_t v;
    v.rst = r; v.cv = cv; v.ordy = ordy; v.exp_ready = er; v.chk_zero = cz;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, check comb ready and buffered token, advance the model.
  task automatic step(input vec_t v);
    tok_t t;
    @(negedge clk);
    rst        = v.rst;
    ctrl_valid = v.cv;
    outs_ready = v.ordy;
    #1;
    check("ctrl_ready", 32'(ctrl_ready), 32'(v.exp_ready));
    check("outs_valid", 32'(outs_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      check("outs", 32'(outs), 32'(sb[0].data));
      check("outs_index", 32'(outs_index), 32'(sb[0].idx));
    end
    if (v.chk_zero) begin
      check("reset_outs", 32'(outs), 32'h0);
      check("reset_index", 32'(outs_index), 32'h0);
    end
    if (v.rst) begin
      sb.delete();
    end else begin
      if (sb.size() != 0 && v.ordy) void'(sb.pop_front());
      if (v.exp_ready != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (v.exp_ready[i]) begin
            t.data = c_tab[i];
            t.idx  = 2'(i);
          end
        end
        sb.push_back(t);
      end
    end
  endtask

  initial begin
    vec_t v;
    n_tests = 0;
    n_fail  = 0;
    c_tab[0] = 12'h5AE; c_tab[1] = 12'hA52; c_tab[2] = 12'h7FF; c_tab[3] = 12'h800;
    rst = 1'b1; ctrl_valid = 4'b0000; outs_ready = 1'b1;

    // Reset, then idle
    add(1, 4'b0000, 1, 4'b0000, 0);
    add(1, 4'b0000, 1, 4'b0000, 0);
    for (int i = 0; i < 5; i++) add(0, 4'b0000, 1, 4'b0000, 1);
    // Single request, then drain
    add(0, 4'b0001, 1, 4'b0001, 0);
    add(0, 4'b0000, 1, 4'b0000, 0);
    // Reset to ptr=0, then all requesting at full throughput
    add(1, 4'b0000, 1, 4'b0000, 0);
    for (int i = 0; i < 8; i++) add(0, 4'b1111, 1, 4'(1 << (i % 4)), 0);
    // Backpressure after the first token (ptr=0 again)
    add(0, 4'b1111, 1, 4'b0001, 0);
    for (int i = 0; i < 3; i++) add(0, 4'b1111, 0, 4'b0000, 0);
    add(0, 4'b1111, 1, 4'b0010, 0);
    add(0, 4'b0000, 1, 4'b0000, 0);
    // Priority wrap: grant 2 leaves ptr=3, then 1001 grants 3 then 0
    add(0, 4'b0100, 1, 4'b0100, 0);
    add(0, 4'b1001, 1, 4'b1000, 0);
    add(0, 4'b1001, 1, 4'b0001, 0);
    add(0, 4'b0000, 1, 4'b0000, 0);
    // Requester withdraws without handshake while stalled: no grant issued
    add(0, 4'b0100, 1, 4'b0100, 0);
    add(0, 4'b0001, 0, 4'b0000, 0);
    add(0, 4'b0000, 1, 4'b0000, 0);

    foreach (vecs[i]) step(vecs[i]);

    // Reset mid-operation with a stalled token (ptr=3 here: 0001 grants 0)
    v.chk_zero = 0;
    v.rst = 0; v.cv = 4'b0001; v.ordy = 1; v.exp_ready = 4'b0001; step(v);
    v.rst = 0; v.cv = 4'b0000; v.ordy = 0; v.exp_ready = 4'b0000; step(v);
    v.rst = 0; v.cv = 4'b0000; v.ordy = 0; v.exp_ready = 4'b0000; step(v);
    v.rst = 1; v.cv = 4'b0000; v.ordy = 0; v.exp_ready = 4'b0000; step(v);
    v.rst = 0; v.cv = 4'b0110; v.ordy = 0; v.exp_ready = 4'b0010; step(v);
    v.rst = 0; v.cv = 4'b0110; v.ordy = 1; v.exp_ready = 4'b0100; step(v);
    v.rst = 0; v.cv = 4'b0000; v.ordy = 1; v.exp_ready = 4'b0000; step(v);
    v.rst = 0; v.cv = 4'b0000; v.ordy = 1; v.exp_ready = 4'b0000; step(v);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
